// File: rtl/dna_pattern_matcher_pkg.sv
// Shared base encodings and helpers for the DNA motif matcher.
package dna_pattern_matcher_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_T = 2'b01,
    BASE_C = 2'b10,
    BASE_G = 2'b11
  } base_t;

  // Watson-Crick complement: A<->T, C<->G is a flip of the low bit.
  function automatic base_t comp(input base_t b);
    return base_t'(b ^ BASE_T);
  endfunction

endpackage

// File: rtl/dna_pattern_matcher_window_cmp.sv
// Compares the newest-first base window against an arrival-order pattern of len bases.
module dna_window_cmp
  import dna_pattern_matcher_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [2*MAX_LEN-1:0] win,
  input  logic [2*MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]     len,
  output logic                 hit
);

  // win[k] is k beats old; it must equal pattern base len-1-k.
  always_comb begin
    hit = (len != '0) && (int'(len) <= MAX_LEN);
    for (int k = 0; k < MAX_LEN; k++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((k + j + 1 == int'(len)) &&
            (base_t'(win[2*k +: 2]) != base_t'(pat[2*j +: 2]))) begin
          hit = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/dna_pattern_matcher.sv
// Streaming DNA motif detector with overlap-aware hits and a saturating hit counter.
// Define DNA_REVCOMP_EN to also detect the reverse-complement strand on match_rc.
module dna_pattern_matcher
  import dna_pattern_matcher_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_load,
  input  logic [2*MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 in_valid,
  input  logic [1:0]           in_base,
  input  logic                 cnt_clr,
  output logic                 match,
  output logic                 match_rc,
  output logic [CNT_W-1:0]     match_count,
  output logic                 cfg_ok
);

  logic [2*MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, win;
  logic [LEN_W-1:0]     fill_q, fill_d, len_q, len_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cfg_ok_q, cfg_ok_d, match_q, match_d, match_rc_q, match_rc_d;
  logic                 fwd_hit, rc_hit, beat, window_full;

  assign win         = {hist_q[2*MAX_LEN-3:0], in_base};
  assign beat        = in_valid & ~cfg_load;
  assign window_full = (int'(fill_q) + 1 >= int'(len_q));

  dna_window_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_fwd_cmp (
    .win (win),
    .pat (pat_q),
    .len (len_q),
    .hit (fwd_hit)
  );

`ifdef DNA_REVCOMP_EN
  logic [2*MAX_LEN-1:0] rc_pat;

  always_comb begin
    rc_pat = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if (i + j + 1 == int'(len_q)) rc_pat[2*i +: 2] = comp(base_t'(pat_q[2*j +: 2]));
      end
    end
  end

  dna_window_cmp #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_rc_cmp (
    .win (win),
    .pat (rc_pat),
    .len (len_q),
    .hit (rc_hit)
  );
`else
  assign rc_hit = 1'b0;
`endif

  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    len_d      = len_q;
    cfg_ok_d   = cfg_ok_q;
    match_d    = beat & cfg_ok_q & window_full & fwd_hit;
    match_rc_d = beat & cfg_ok_q & window_full & rc_hit;
    cnt_d      = cnt_q;

    if (cfg_load) begin
      pat_d    = cfg_pattern;
      len_d    = cfg_len;
      fill_d   = '0;
      cfg_ok_d = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
    end else if (in_valid) begin
      hist_d = win;
      if (int'(fill_q) < MAX_LEN) fill_d = fill_q + LEN_W'(1);
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if ((match_d | match_rc_d) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q     <= '0;
      fill_q     <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      cfg_ok_q   <= 1'b0;
      match_q    <= 1'b0;
      match_rc_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      cfg_ok_q   <= cfg_ok_d;
      match_q    <= match_d;
      match_rc_q <= match_rc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign match       = match_q;
  assign match_rc    = match_rc_q;
  assign match_count = cnt_q;
  assign cfg_ok      = cfg_ok_q;

endmodule
